// File: rtl/writeback_arbiter.sv
// Writeback stage: merges ALU and load results onto the register file write port.
// Loads are aligned and extended here; ALU results wait in a small FIFO.
module writeback_arbiter #(
  parameter int DATA_WIDTH     = 64,
  parameter int NUM_REGS       = 32,
  parameter int NUM_REGS_LOG   = $clog2(NUM_REGS),
  parameter int ALU_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [NUM_REGS_LOG-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [NUM_REGS_LOG-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]   mem_data,
  input  logic [2:0]              mem_funct3,
  input  logic [2:0]              mem_addr_lo,
  output logic [NUM_REGS_LOG-1:0] write_reg,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic                    wb_valid,
  output logic [NUM_REGS_LOG-1:0] wb_rd
);

  localparam int PW = $clog2(ALU_FIFO_DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [NUM_REGS_LOG-1:0] fifo_rd  [ALU_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_val [ALU_FIFO_DEPTH];
  logic [PW-1:0]           wptr;
  logic [PW-1:0]           rptr;
  logic [PW:0]             count;
  logic [CW-1:0]           starve_cnt;

  logic empty;
  logic full;
  logic at_limit;
  logic grant_mem;
  logic grant_alu;
  logic push;
  logic pop;

  assign empty     = (count == '0);
  assign full      = (count == (PW+1)'(ALU_FIFO_DEPTH));
  assign at_limit  = (starve_cnt == CW'(STARVE_LIMIT));
  assign grant_mem = mem_valid & ~(at_limit & ~empty);
  assign grant_alu = ~empty & ~grant_mem;
  assign alu_ready = ~full & ~reset;
  assign mem_ready = grant_mem & ~reset;
  assign push      = alu_valid & alu_ready;
  assign pop       = grant_alu;

  // Load alignment: low offset bits below the access size drop out.
  logic [7:0]            lb;
  logic [15:0]           lh;
  logic [31:0]           lw;
  logic [DATA_WIDTH-1:0] load_val;

  assign lb = 8'(mem_data >> {mem_addr_lo, 3'b000});
  assign lh = 16'(mem_data >> {mem_addr_lo[2:1], 4'b0000});
  assign lw = 32'(mem_data >> {mem_addr_lo[2], 5'b00000});

  always_comb begin
    load_val = '0;
    case (mem_funct3)
      3'b000:  load_val = {{(DATA_WIDTH-8){lb[7]}}, lb};
      3'b001:  load_val = {{(DATA_WIDTH-16){lh[15]}}, lh};
      3'b010:  load_val = {{(DATA_WIDTH-32){lw[31]}}, lw};
      3'b011:  load_val = mem_data;
      3'b100:  load_val = {{(DATA_WIDTH-8){1'b0}}, lb};
      3'b101:  load_val = {{(DATA_WIDTH-16){1'b0}}, lh};
      3'b110:  load_val = {{(DATA_WIDTH-32){1'b0}}, lw};
      default: load_val = '0;
    endcase
  end

  logic [NUM_REGS_LOG-1:0] sel_rd;
  logic [DATA_WIDTH-1:0]   sel_val;

  always_comb begin
    sel_rd  = fifo_rd[rptr];
    sel_val = fifo_val[rptr];
    if (grant_mem) begin
      sel_rd  = mem_rd;
      sel_val = load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wptr]  <= alu_rd;
      fifo_val[wptr] <= alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Counts loads that overtook a waiting ALU result.
  always_ff @(posedge clk) begin
    if (reset || empty || grant_alu) begin
      starve_cnt <= '0;
    end else if (grant_mem && !at_limit) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_reg  <= '0;
      write_data <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
    end else if (grant_mem || grant_alu) begin
      write_reg  <= sel_rd;
      write_data <= (sel_rd == '0) ? '0 : sel_val;
      wb_valid   <= 1'b1;
      wb_rd      <= sel_rd;
    end else begin
      write_reg  <= '0;
      write_data <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: load formatting table,
// ALU latency, starvation pattern and mid-operation reset.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_result;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [63:0] mem_data;
  logic [2:0]  mem_funct3;
  logic [2:0]  mem_addr_lo;
  logic [4:0]  write_reg;
  logic [63:0] write_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;

  writeback_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_rd(alu_rd), .alu_result(alu_result),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
    .write_reg(write_reg), .write_data(write_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  int ncmp  = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [2:0]  off;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [4:0]  exp_wr;
    logic [63:0] exp_wd;
  } ld_vec_t;

  localparam logic [63:0] D1 = 64'hF0E0_D0C0_B0A0_9080;
  localparam logic [63:0] D2 = 64'h0123_4567_89AB_CDEF;

  ld_vec_t lv[14];

  // 0 idle, 1 next load, 2 next ALU entry
  int   kind[17]   = '{0,1,1,1,1,2,1,1,1,1,2,1,1,1,1,2,1};
  logic ar_exp[17] = '{1,1,0,0,0,0,1,0,0,0,0,1,1,1,1,1,1};

  initial begin
    lv[0]  = '{3'b000, 3'd1, 5'd5,  D1, 5'd5,  64'hFFFF_FFFF_FFFF_FF90};
    lv[1]  = '{3'b000, 3'd2, 5'd5,  D1, 5'd5,  64'hFFFF_FFFF_FFFF_FFA0};
    lv[2]  = '{3'b100, 3'd1, 5'd6,  D1, 5'd6,  64'h0000_0000_0000_0090};
    lv[3]  = '{3'b100, 3'd2, 5'd6,  D1, 5'd6,  64'h0000_0000_0000_00A0};
    lv[4]  = '{3'b001, 3'd6, 5'd7,  D1, 5'd7,  64'hFFFF_FFFF_FFFF_F0E0};
    lv[5]  = '{3'b001, 3'd1, 5'd7,  D1, 5'd7,  64'hFFFF_FFFF_FFFF_9080};
    lv[6]  = '{3'b101, 3'd3, 5'd8,  D1, 5'd8,  64'h0000_0000_0000_B0A0};
    lv[7]  = '{3'b010, 3'd0, 5'd9,  D1, 5'd9,  64'hFFFF_FFFF_B0A0_9080};
    lv[8]  = '{3'b110, 3'd4, 5'd10, D1, 5'd10, 64'h0000_0000_F0E0_D0C0};
    lv[9]  = '{3'b011, 3'd5, 5'd11, D1, 5'd11, D1};
    lv[10] = '{3'b010, 3'd6, 5'd12, D2, 5'd12, 64'h0000_0000_0123_4567};
    lv[11] = '{3'b000, 3'd0, 5'd13, D2, 5'd13, 64'hFFFF_FFFF_FFFF_FFEF};
    lv[12] = '{3'b111, 3'd0, 5'd14, D1, 5'd14, 64'h0};
    lv[13] = '{3'b011, 3'd0, 5'd0,  D1, 5'd0,  64'h0};

    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
    mem_valid = 1'b1; mem_rd = 5'd1; mem_data = D1;
    mem_funct3 = 3'b011; mem_addr_lo = '0;
    tick;
    tick;
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_write_reg", write_reg, 0);
    chk("rst_wb_valid", wb_valid, 0);

    reset = 1'b0;
    mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("idle%0d_write_reg", i), write_reg, 0);
      chk($sformatf("idle%0d_write_data", i), write_data, 0);
      chk($sformatf("idle%0d_wb_valid", i), wb_valid, 0);
      chk($sformatf("idle%0d_alu_ready", i), alu_ready, 1);
      chk($sformatf("idle%0d_mem_ready", i), mem_ready, 0);
    end

    for (int i = 0; i < 14; i++) begin
      mem_valid = 1'b1;
      mem_funct3 = lv[i].f3;
      mem_addr_lo = lv[i].off;
      mem_rd = lv[i].rd;
      mem_data = lv[i].data;
      #1;
      chk($sformatf("ld%0d_mem_ready", i), mem_ready, 1);
      tick;
      mem_valid = 1'b0;
      chk($sformatf("ld%0d_write_reg", i), write_reg, lv[i].exp_wr);
      chk($sformatf("ld%0d_write_data", i), write_data, lv[i].exp_wd);
      chk($sformatf("ld%0d_wb_valid", i), wb_valid, 1);
      chk($sformatf("ld%0d_wb_rd", i), wb_rd, lv[i].exp_wr);
    end
    tick;

    alu_valid = 1'b1; alu_rd = 5'd3; alu_result = 64'h1234;
    #1;
    chk("alu_ready_single", alu_ready, 1);
    tick;
    alu_valid = 1'b0;
    chk("alu_not_yet", wb_valid, 0);
    tick;
    chk("alu_write_reg", write_reg, 3);
    chk("alu_write_data", write_data, 64'h1234);
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_rd", wb_rd, 3);

    alu_valid = 1'b1; alu_rd = 5'd0; alu_result = 64'hDEAD;
    tick;
    alu_valid = 1'b0;
    tick;
    chk("x0_write_reg", write_reg, 0);
    chk("x0_write_data", write_data, 0);
    chk("x0_wb_valid", wb_valid, 1);
    chk("x0_wb_rd", wb_rd, 0);
    tick;

    begin
      int li, ai, le, ae;
      li = 0; ai = 0; le = 0; ae = 0;
      mem_funct3 = 3'b011;
      mem_addr_lo = '0;
      for (int c = 0; c < 17; c++) begin
        logic [4:0]  ewr;
        logic [63:0] ewd;
        mem_valid = (c >= 1);
        mem_rd = 5'(16 + li);
        mem_data = 64'h1000 + 64'(li);
        alu_valid = (ai < 3);
        alu_rd = 5'(10 + ai);
        alu_result = 64'hA0 + 64'(ai);
        #1;
        chk($sformatf("st%0d_alu_ready", c), alu_ready, ar_exp[c]);
        chk($sformatf("st%0d_mem_ready", c), mem_ready, kind[c] == 1);
        if (alu_valid && alu_ready) ai++;
        if (mem_valid && mem_ready) li++;
        tick;
        ewr = '0;
        ewd = '0;
        if (kind[c] == 1) begin
          ewr = 5'(16 + le);
          ewd = 64'h1000 + 64'(le);
          le++;
        end else if (kind[c] == 2) begin
          ewr = 5'(10 + ae);
          ewd = 64'hA0 + 64'(ae);
          ae++;
        end
        chk($sformatf("st%0d_write_reg", c), write_reg, ewr);
        chk($sformatf("st%0d_write_data", c), write_data, ewd);
        chk($sformatf("st%0d_wb_valid", c), wb_valid, kind[c] != 0);
      end
      mem_valid = 1'b0;
      alu_valid = 1'b0;
      tick;
      chk("st_drained", wb_valid, 0);
    end

    alu_valid = 1'b1; alu_rd = 5'd7; alu_result = 64'h77;
    #1;
    chk("rm_alu_ready0", alu_ready, 1);
    tick;
    alu_rd = 5'd8; alu_result = 64'h88;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 64'h99;
    mem_funct3 = 3'b011;
    #1;
    chk("rm_alu_ready1", alu_ready, 1);
    chk("rm_mem_ready", mem_ready, 1);
    tick;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    chk("rm_load_out", write_reg, 9);
    reset = 1'b1;
    #1;
    chk("rm_rst_alu_ready", alu_ready, 0);
    chk("rm_rst_mem_ready", mem_ready, 0);
    tick;
    reset = 1'b0;
    chk("rm_write_reg", write_reg, 0);
    chk("rm_write_data", write_data, 0);
    chk("rm_wb_valid", wb_valid, 0);
    chk("rm_wb_rd", wb_rd, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("rm_post%0d_wb_valid", i), wb_valid, 0);
      chk($sformatf("rm_post%0d_write_reg", i), write_reg, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
